// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 3 columns of a 3x4 keypad, debounces whole scans and
// emits one-cycle press events. Define KEYPAD_REPEAT_EN to add auto-repeat of a held key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] KEY_ROW,
  output logic [2:0] KEY_COL,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2} col_e;

  generate
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scanner: illegal parameter value");
    end
  endgenerate

  logic [3:0]        row_meta_q, row_meta_d, row_s_q, row_s_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  col_e              col_idx_q, col_idx_d;
  logic [2:0]        key_col_q, key_col_d;
  logic [3:0]        raw0_q, raw0_d, raw1_q, raw1_d;
  logic [11:0]       last_snap_q, last_snap_d, stable_q, stable_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d, stab_next;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d, multi_key_q, multi_key_d;
  logic [3:0]        key_code_q, key_code_d;

  logic [11:0] new_snap;
  logic [3:0]  new_count;
  logic        sample_edge, scan_end, commit, press_evt, rep_fire;

  function automatic logic [3:0] count_keys(input logic [11:0] snap);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'b000, snap[i]};
    return n;
  endfunction

  // Bit index row*3+col maps onto the printed labels; row 3 holds *, 0, #.
  function automatic logic [3:0] encode_key(input logic [11:0] snap);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < 12; i++) begin
      if (snap[i]) begin
        case (i)
          9:       code = 4'd10;
          10:      code = 4'd0;
          11:      code = 4'd11;
          default: code = 4'(i + 1);
        endcase
      end
    end
    return code;
  endfunction

  assign sample_edge = (div_cnt_q == DIV_LAST);
  assign scan_end    = sample_edge && (col_idx_q == COL2);
  assign new_count   = count_keys(new_snap);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    row_meta_d = KEY_ROW;
    row_s_d    = row_meta_q;
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    col_idx_d  = col_idx_q;
    key_col_d  = key_col_q;
    raw0_d     = raw0_q;
    raw1_d     = raw1_q;
    if (sample_edge) begin
      div_cnt_d = '0;
      key_col_d = {key_col_q[1:0], key_col_q[2]};
      case (col_idx_q)
        COL0: begin
          raw0_d    = row_s_q;
          col_idx_d = COL1;
        end
        COL1: begin
          raw1_d    = row_s_q;
          col_idx_d = COL2;
        end
        default: col_idx_d = COL0;
      endcase
    end
  end

  // Column 2 is never stored: at scan end it is taken straight from the synchroniser.
  always_comb begin
    new_snap = '0;
    for (int r = 0; r < 4; r++) begin
      new_snap[r*3]     = raw0_q[r];
      new_snap[r*3 + 1] = raw1_q[r];
      new_snap[r*3 + 2] = row_s_q[r];
    end
  end

  always_comb begin
    last_snap_d = last_snap_q;
    stab_cnt_d  = stab_cnt_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    commit      = 1'b0;
    press_evt   = 1'b0;
    if (new_snap != last_snap_q)   stab_next = STAB_W'(1);
    else if (stab_cnt_q == STAB_MAX) stab_next = STAB_MAX;
    else                           stab_next = stab_cnt_q + STAB_W'(1);
    if (scan_end) begin
      last_snap_d = new_snap;
      stab_cnt_d  = stab_next;
      if (stab_next == STAB_MAX && new_snap != stable_q) begin
        commit      = 1'b1;
        stable_d    = new_snap;
        key_held_d  = (new_count == 4'd1);
        multi_key_d = (new_count >= 4'd2);
        // Only a lone key out of an all-released state counts as a press.
        if (new_count == 4'd1 && stable_q == '0) begin
          press_evt  = 1'b1;
          key_code_d = encode_key(new_snap);
        end
      end
    end
  end

  assign key_valid_d = press_evt | rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= '0;
      row_s_q     <= '0;
      div_cnt_q   <= '0;
      col_idx_q   <= COL0;
      key_col_q   <= 3'b001;
      raw0_q      <= '0;
      raw1_q      <= '0;
      last_snap_q <= '0;
      stab_cnt_q  <= '0;
      stable_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      key_col_q   <= key_col_d;
      raw0_q      <= raw0_d;
      raw1_q      <= raw1_d;
      last_snap_q <= last_snap_d;
      stab_cnt_q  <= stab_cnt_d;
      stable_q    <= stable_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic             rep_armed_q, rep_armed_d, rep_first_q, rep_first_d;

  // Armed only by a real press event; any commit disarms or re-arms from zero.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    rep_next    = rep_cnt_q + REP_W'(1);
    if (scan_end) begin
      if (commit) begin
        rep_armed_d = press_evt;
        rep_first_d = 1'b1;
        rep_cnt_d   = '0;
      end else if (rep_armed_q) begin
        if (rep_next == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE))) begin
          rep_fire    = 1'b1;
          rep_first_d = 1'b0;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign KEY_COL   = key_col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed segment table, reset/repeat sequences and a
// randomized run against a scan-level model of the keypad and debounce rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 3;
  localparam int REP_DELAY = 4;
  localparam int REP_RATE  = 2;
  localparam int SCAN_CYC  = 3 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  localparam logic [11:0] K1 = 12'h001, K2 = 12'h002, K3 = 12'h004, K5 = 12'h010;
  localparam logic [11:0] K7 = 12'h040, K0 = 12'h400, KH = 12'h800, NONE = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic        key_valid, key_held, multi_key;
  logic [3:0]  key_code;
  logic [11:0] pressed = '0;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_RATE(REP_RATE)
  ) dut (
    .clk(clk), .rst(rst), .KEY_ROW(key_row), .KEY_COL(key_col),
    .key_valid(key_valid), .key_code(key_code),
    .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column drive.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++) key_row[r] = |(pressed[r*3 +: 3] & key_col);
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic [2:0] exp_col(input int i);
    if (i < SCAN_DIV)          return 3'b001;
    else if (i < 2 * SCAN_DIV) return 3'b010;
    else if (i < 3 * SCAN_DIV) return 3'b100;
    else                       return 3'b001;
  endfunction

  // Scan-level reference: snapshot history, committed state, repeat timing.
  logic [11:0] m_hist[$];
  logic [11:0] m_stable;
  int          m_code, m_since;
  bit          m_held, m_multi, m_armed;
  int          code_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  task automatic model_reset();
    m_hist.delete();
    m_stable = '0;
    m_code   = 0;
    m_since  = 0;
    m_held   = 1'b0;
    m_multi  = 1'b0;
    m_armed  = 1'b0;
  endtask

  task automatic model_step(input logic [11:0] snap, output int pulses);
    bit steady;
    bit ev;
    int n;
    pulses = 0;
    m_hist.push_back(snap);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    steady = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] != snap) steady = 1'b0;
    if (steady && snap != m_stable) begin
      n  = $countones(snap);
      ev = (n == 1) && (m_stable == '0);
      if (ev) begin
        for (int i = 0; i < 12; i++) if (snap[i]) m_code = code_of[i];
        pulses = 1;
      end
      m_stable = snap;
      m_held   = (n == 1);
      m_multi  = (n >= 2);
      m_armed  = ev && (REP_ON == 1);
      m_since  = 0;
    end else if (m_armed) begin
      m_since++;
      if (m_since == REP_DELAY ||
          (m_since > REP_DELAY && (m_since - REP_DELAY) % REP_RATE == 0)) pulses++;
    end
  endtask

  // Called on a negedge just after a scan end; returns on the negedge after the next one.
  task automatic run_scan(input logic [11:0] p, output int pulses, output int col_bad);
    pressed = p;
    pulses  = 0;
    col_bad = 0;
    for (int i = 1; i <= SCAN_CYC; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (key_col != exp_col(i)) col_bad++;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [11:0] keys;
    int          scans;
    int          pulses;
    int          code;
    bit          held;
    bit          multi;
  } seg_t;

  seg_t tbl[$];

  initial begin
    int p, cb, tot_p, tot_cb, mp, sel, len;
    logic [11:0] pat;

    tbl.push_back(seg_t'{NONE, 20, 0,          0,  1'b0, 1'b0});
    tbl.push_back(seg_t'{K5,    3, 1,          5,  1'b1, 1'b0});
    tbl.push_back(seg_t'{K5,    7, 2 * REP_ON, 5,  1'b1, 1'b0});
    tbl.push_back(seg_t'{NONE,  2, REP_ON,     5,  1'b1, 1'b0});
    tbl.push_back(seg_t'{NONE,  1, 0,          5,  1'b0, 1'b0});
    for (int b = 0; b < 3; b++) begin
      tbl.push_back(seg_t'{KH,   1, 0, 5, 1'b0, 1'b0});
      tbl.push_back(seg_t'{NONE, 1, 0, 5, 1'b0, 1'b0});
    end
    tbl.push_back(seg_t'{KH,      3, 1, 11, 1'b1, 1'b0});
    tbl.push_back(seg_t'{NONE,    3, 0, 11, 1'b0, 1'b0});
    tbl.push_back(seg_t'{K1 | K3, 3, 0, 11, 1'b0, 1'b1});
    tbl.push_back(seg_t'{K1,      3, 0, 11, 1'b1, 1'b0});
    tbl.push_back(seg_t'{NONE,    3, 0, 11, 1'b0, 1'b0});
    tbl.push_back(seg_t'{K0,      3, 1, 0,  1'b1, 1'b0});
    tbl.push_back(seg_t'{K2,      3, 0, 0,  1'b1, 1'b0});
    tbl.push_back(seg_t'{NONE,    3, 0, 0,  1'b0, 1'b0});

    do_reset();
    check("reset key_col", int'(key_col), 1);
    check("reset key_code", int'(key_code), 0);

    foreach (tbl[t]) begin
      tot_p  = 0;
      tot_cb = 0;
      for (int s = 0; s < tbl[t].scans; s++) begin
        run_scan(tbl[t].keys, p, cb);
        tot_p  += p;
        tot_cb += cb;
      end
      check($sformatf("seg%0d pulses", t), tot_p, tbl[t].pulses);
      check($sformatf("seg%0d key_code", t), int'(key_code), tbl[t].code);
      check($sformatf("seg%0d key_held", t), int'(key_held), int'(tbl[t].held));
      check($sformatf("seg%0d multi_key", t), int'(multi_key), int'(tbl[t].multi));
      check($sformatf("seg%0d key_col", t), tot_cb, 0);
    end

    // Reset in the middle of a scan while key 7 is held.
    do_reset();
    for (int s = 0; s < DEB; s++) run_scan(K7, p, cb);
    check("pre-reset key_held", int'(key_held), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("in-reset key_col", int'(key_col), 1);
    check("in-reset key_valid", int'(key_valid), 0);
    check("in-reset key_code", int'(key_code), 0);
    check("in-reset key_held", int'(key_held), 0);
    check("in-reset multi_key", int'(multi_key), 0);
    repeat (2) @(negedge clk);
    check("in-reset key_col late", int'(key_col), 1);
    rst = 1'b0;
    for (int s = 1; s <= DEB; s++) begin
      run_scan(K7, p, cb);
      check($sformatf("post-reset scan%0d pulses", s), p, (s == DEB) ? 1 : 0);
      check($sformatf("post-reset scan%0d key_code", s), int'(key_code), (s == DEB) ? 7 : 0);
    end
    check("post-reset key_held", int'(key_held), 1);

`ifdef KEYPAD_REPEAT_EN
    // Press at scan 3, then repeats 4, 6, 8, 10 and 12 scans after it.
    do_reset();
    for (int s = 1; s <= 15; s++) begin
      run_scan(K2, p, cb);
      check($sformatf("repeat scan%0d pulses", s), p,
            (s == 3 || s == 7 || s == 9 || s == 11 || s == 13 || s == 15) ? 1 : 0);
      if (p != 0) check($sformatf("repeat scan%0d key_code", s), int'(key_code), 2);
    end
`endif

    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      pat = '0;
      else if (sel < 8) pat = 12'(1) << $urandom_range(0, 11);
      else              pat = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        model_step(pat, mp);
        run_scan(pat, p, cb);
        check($sformatf("rand%0d.%0d pulses", n, s), p, mp);
        check($sformatf("rand%0d.%0d key_code", n, s), int'(key_code), m_code);
        check($sformatf("rand%0d.%0d key_held", n, s), int'(key_held), int'(m_held));
        check($sformatf("rand%0d.%0d multi_key", n, s), int'(multi_key), int'(m_multi));
        check($sformatf("rand%0d.%0d key_col", n, s), cb, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
